// File: rtl/enduro_fifo_rd_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : enduro_fifo_rd_stage
// Description : Read-side output stage of the enduro FIFO. Pops the FIFO
//               controller, captures the 1-cycle-latency memory read data into
//               a small skid buffer and presents it as an AXI-Stream master.
//               Credit-based prefetch sustains one beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module enduro_fifo_rd_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 3
) (
   input  logic                               m_axis_clk,
   input  logic                               m_axis_aresetn,
   input  logic                               empty_ff,
   output logic                               inc_rd_pointer,
   input  logic [DATA_WIDTH-1:0]              mem_rd_data,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic [DATA_WIDTH-1:0]              m_axis_tdata,
   output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BUF_DEPTH - 1);

   logic [CNT_W-1:0]      occupancy;
   logic                  inflight;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      head_idx;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] head_data;
   logic [DATA_WIDTH-1:0] tdata_reg;
   logic [CNT_W:0]        credit_used;
   logic                  capture;
   logic                  handshake;

   // Circular index advance over BUF_DEPTH slots (depth need not be a power of two).
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Credit counts both held beats and the beat still in the memory pipeline,
   // so the buffer can never be overrun; it depends on registered state only.
   assign credit_used    = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight};
   assign inc_rd_pointer = ~empty_ff & (credit_used < {1'b0, DEPTH_CNT});

   assign capture        = inflight;
   assign m_axis_tvalid  = (occupancy != '0);
   assign handshake      = m_axis_tvalid & m_axis_tready;
   assign m_axis_tdata   = tdata_reg;
   assign buf_count      = occupancy;

   // Slot that will be at the head of the buffer after this cycle's updates.
   assign head_idx = handshake ? wrap_inc(rd_idx) : rd_idx;

   // Next head value; bypass the memory data when it lands directly in the head slot.
   always_comb begin
      head_data = buf_mem[head_idx];
      if (capture && (head_idx == wr_idx)) begin
         head_data = mem_rd_data;
      end
   end

   // Control state: pipeline tracking, buffer indices, occupancy and the output data register.
   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         inflight  <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         occupancy <= '0;
         tdata_reg <= '0;
      end else begin
         inflight  <= inc_rd_pointer;
         tdata_reg <= head_data;
         if (capture) begin
            wr_idx <= wrap_inc(wr_idx);
         end
         if (handshake) begin
            rd_idx <= wrap_inc(rd_idx);
         end
         case ({capture, handshake})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Skid buffer storage; contents are qualified by occupancy so need no reset.
   always_ff @(posedge m_axis_clk) begin
      if (capture) begin
         buf_mem[wr_idx] <= mem_rd_data;
      end
   end

   a_no_overflow: assert property (@(posedge m_axis_clk) disable iff (!m_axis_aresetn)
      !(capture && (occupancy == DEPTH_CNT) && !handshake));

   a_no_pop_when_empty: assert property (@(posedge m_axis_clk) disable iff (!m_axis_aresetn)
      !(inc_rd_pointer && empty_ff));

endmodule
`default_nettype wire

// File: tb/tb_enduro_fifo_rd_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_enduro_fifo_rd_stage
// Description : Scoreboard bench for enduro_fifo_rd_stage. The bench plays the
//               FIFO controller and memory; words popped are queued as the
//               expected beat order, and a monitor compares every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enduro_fifo_rd_stage;

   localparam int DW    = 32;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          empty_ff = 1'b1;
   logic          inc_rd_pointer;
   logic [DW-1:0] mem_rd_data = '0;
   logic          tvalid;
   logic          tready = 1'b0;
   logic [DW-1:0] tdata;
   logic [CW-1:0] buf_count;

   enduro_fifo_rd_stage #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
      .m_axis_clk     (clk),
      .m_axis_aresetn (rst_n),
      .empty_ff       (empty_ff),
      .inc_rd_pointer (inc_rd_pointer),
      .mem_rd_data    (mem_rd_data),
      .m_axis_tvalid  (tvalid),
      .m_axis_tready  (tready),
      .m_axis_tdata   (tdata),
      .buf_count      (buf_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] src[$];     // words held by the FIFO controller
   logic [DW-1:0] exp_q[$];   // expected beat order
   int            occ  = 0;   // beats that should be in the buffer
   int            infl = 0;   // beat travelling through memory
   bit            pend = 0;
   logic [DW-1:0] pend_word = '0;
   bit            stall = 0;
   logic [DW-1:0] stall_data = '0;
   bit            prev_tv = 0;

   int            pop_count, beat_count;
   int            first_pop_cyc, first_tv_cyc, first_beat_cyc, last_beat_cyc;
   logic [DW-1:0] first_beat_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic clear_track();
      pop_count = 0; beat_count = 0;
      first_pop_cyc = -1; first_tv_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
      first_beat_data = '0;
   endtask

   // Inputs change one time unit after the active edge.
   task automatic tick(input bit rdy, input bit gate);
      @(posedge clk);
      #1;
      cyc++;
      tready   = rdy;
      empty_ff = (src.size() == 0) || gate || !rst_n;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((src.size() != 0 || exp_q.size() != 0) && n < bound) begin
         tick(1'b1, 1'b0);
         n++;
      end
      tick(1'b1, 1'b0);
      chk("drain_left", src.size() + exp_q.size(), 0);
   endtask

   // Memory model: data for a pop appears in the following cycle only.
   always @(posedge clk) mem_rd_data <= pend ? pend_word : $urandom;

   // Monitor / reference model, evaluated away from the active edge.
   always @(negedge clk) begin
      logic [DW-1:0] w;
      if (!rst_n) begin
         exp_q.delete();
         occ = 0; infl = 0; pend = 0; stall = 0; prev_tv = 0;
      end else begin
         chk("tvalid", tvalid, (occ != 0));
         chk("buf_count", buf_count, occ);
         chk("pop_rule", inc_rd_pointer, (!empty_ff && (occ + infl < DEPTH)));
         if (stall) begin
            chk("hold_tvalid", tvalid, 1);
            chk("hold_tdata", tdata, stall_data);
         end
         if (tvalid && !prev_tv && first_tv_cyc < 0) first_tv_cyc = cyc;
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", tdata, 32'hDEAD_BEEF);
            end else begin
               chk("beat_data", tdata, exp_q.pop_front());
            end
            if (beat_count == 0) begin
               first_beat_cyc  = cyc;
               first_beat_data = tdata;
            end
            last_beat_cyc = cyc;
            beat_count++;
         end
         pend = 0;
         if (inc_rd_pointer) begin
            if (src.size() == 0) begin
               chk("pop_with_no_data", inc_rd_pointer, 0);
            end else begin
               w = src.pop_front();
               exp_q.push_back(w);
               pend      = 1;
               pend_word = w;
               if (pop_count == 0) first_pop_cyc = cyc;
               pop_count++;
            end
         end
         stall      = tvalid && !tready;
         stall_data = tdata;
         prev_tv    = tvalid;
         occ        = occ + infl - ((tvalid && tready) ? 1 : 0);
         infl       = inc_rd_pointer ? 1 : 0;
      end
   end

   initial begin
      clear_track();
      // 1: reset, then idle with an empty FIFO
      repeat (3) tick(1'b0, 1'b0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_buf_count", buf_count, 0);
      chk("rst_inc", inc_rd_pointer, 0);
      rst_n = 1'b1;
      repeat (20) begin
         tick(1'b1, 1'b0);
         chk("idle_tvalid", tvalid, 0);
         chk("idle_inc", inc_rd_pointer, 0);
      end

      // 2: single word, pipeline latency
      clear_track();
      src.push_back(32'hA5A5_0001);
      repeat (8) tick(1'b1, 1'b0);
      chk("single_latency", first_tv_cyc - first_pop_cyc, 2);
      chk("single_data", first_beat_data, 32'hA5A5_0001);
      chk("single_beats", beat_count, 1);
      chk("single_tvalid_after", tvalid, 0);

      // 3: 64-word stream at full rate
      clear_track();
      for (int i = 0; i < 64; i++) src.push_back(i);
      drain(200);
      chk("stream_pops", pop_count, 64);
      chk("stream_beats", beat_count, 64);
      chk("stream_no_bubble", last_beat_cyc - first_beat_cyc, 63);

      // 4: back-pressure fills the buffer, then releases
      clear_track();
      for (int i = 0; i < 10; i++) src.push_back(32'h4000_0000 + i);
      repeat (25) tick(1'b0, 1'b0);
      chk("bp_pops", pop_count, DEPTH);
      chk("bp_buf_count", buf_count, DEPTH);
      chk("bp_tvalid", tvalid, 1);
      drain(100);
      chk("bp_beats", beat_count, 10);

      // 5: random ready and random empty gating
      clear_track();
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 9) < 4) src.push_back($urandom);
         tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      end
      drain(3000);
      chk("rand_pop_eq_beat", pop_count, beat_count);

      // 6: asynchronous reset with a beat in flight and two buffered
      for (int i = 0; i < 6; i++) src.push_back(32'h6000_0000 + i);
      begin
         int n = 0;
         tick(1'b0, 1'b0);
         while (buf_count != 2 && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
         end
      end
      chk("pre_rst_buf_count", buf_count, 2);
      chk("pre_rst_inflight", infl, 1);
      #2;
      rst_n = 1'b0;
      src.delete();
      empty_ff = 1'b1;
      #1;
      chk("async_rst_tvalid", tvalid, 0);
      chk("async_rst_buf_count", buf_count, 0);
      repeat (3) tick(1'b1, 1'b0);
      rst_n = 1'b1;
      clear_track();
      src.push_back(32'h0000_1234);
      drain(20);
      chk("post_rst_beats", beat_count, 1);
      chk("post_rst_first", first_beat_data, 32'h0000_1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
